hazard_unit: RTL and testbench

//  Responder to the pipelined controller's E/M/W control stream. Tracks destination tags and

---
 rtl/hazard_unit_if.sv | 30 +++
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: D/E control stream from the controller and stall/flush/forward controls back.
// master = controller/datapath side, slave = hazard_unit.
interface hazard_unit_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] RA1D;
  logic [REG_AW-1:0] RA2D;
  logic [REG_AW-1:0] WA3D;
  logic              RegWriteD;
  logic              MemtoRegD;
  logic              PCSrcD;
  logic              CondExE;
  logic              BranchTakenE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit with E/M/W shadow tags; HAZARD_FORWARD_EN selects forwarding, else RAW stalls.
// Latency: outputs are combinational (0 cycles) from shadow state and current inputs.
// Backpressure: none accepted; it generates the stall/flush controls for the pipeline itself.
module hazard_unit #(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);

  typedef logic [REG_AW-1:0] tag_t;
  localparam tag_t PcTag = tag_t'(PC_REG);

  // The PC is never renamed through the register file, so it never creates a dependency.
  function automatic logic tagMatch(input tag_t a, input tag_t b);
    return (a == b) && (a != PcTag);
  endfunction

  logic validD;
  logic regWriteDg;
  logic pcSrcDg;

  tag_t wa3E;
  logic regWriteE;
  logic pcSrcE;
  tag_t wa3M;
  logic regWriteM;
  logic pcSrcM;
  logic pcSrcW;

  logic dataStall;
  logic pcWrPend;
  logic stallD;
  logic flushD;
  logic flushE;

  assign regWriteDg = hz.RegWriteD & validD;
  assign pcSrcDg    = hz.PCSrcD & validD;
  assign pcWrPend   = pcSrcDg | pcSrcE | pcSrcM;

`ifdef HAZARD_FORWARD_EN
  tag_t ra1E;
  tag_t ra2E;
  logic memtoRegE;
  tag_t wa3W;
  logic regWriteW;

  function automatic logic [1:0] fwdSel(input tag_t ra);
    if (tagMatch(ra, wa3M) && regWriteM)
      return 2'b10;
    else if (tagMatch(ra, wa3W) && regWriteW)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign dataStall = validD & memtoRegE & regWriteE &
                     (tagMatch(hz.RA1D, wa3E) | tagMatch(hz.RA2D, wa3E));
  assign hz.ForwardAE = fwdSel(ra1E);
  assign hz.ForwardBE = fwdSel(ra2E);
`else
  logic unusedMemtoRegD;

  assign unusedMemtoRegD = hz.MemtoRegD;
  assign dataStall = validD &
                     ((tagMatch(hz.RA1D, wa3E) & regWriteE) | (tagMatch(hz.RA1D, wa3M) & regWriteM) |
                      (tagMatch(hz.RA2D, wa3E) & regWriteE) | (tagMatch(hz.RA2D, wa3M) & regWriteM));
  assign hz.ForwardAE = 2'b00;
  assign hz.ForwardBE = 2'b00;
`endif

  // A taken branch overrides the load stall: D and E are both squashed, so the held D is discarded.
  assign stallD     = dataStall;
  assign flushD     = pcWrPend | pcSrcW | hz.BranchTakenE;
  assign flushE     = dataStall | hz.BranchTakenE;
  assign hz.StallF  = dataStall | pcWrPend;
  assign hz.StallD  = stallD;
  assign hz.FlushD  = flushD;
  assign hz.FlushE  = flushE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      validD <= 1'b0;
    else if (flushD)
      validD <= 1'b0;
    else if (!stallD)
      validD <= 1'b1;
  end

  // E stage loads a clean bubble both when flushed and when D holds no valid instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa3E      <= '0;
      regWriteE <= 1'b0;
      pcSrcE    <= 1'b0;
`ifdef HAZARD_FORWARD_EN
      ra1E      <= '0;
      ra2E      <= '0;
      memtoRegE <= 1'b0;
`endif
    end else if (flushE || !validD) begin
      wa3E      <= '0;
      regWriteE <= 1'b0;
      pcSrcE    <= 1'b0;
`ifdef HAZARD_FORWARD_EN
      ra1E      <= '0;
      ra2E      <= '0;
      memtoRegE <= 1'b0;
`endif
    end else begin
      wa3E      <= hz.WA3D;
      regWriteE <= regWriteDg;
      pcSrcE    <= pcSrcDg;
`ifdef HAZARD_FORWARD_EN
      ra1E      <= hz.RA1D;
      ra2E      <= hz.RA2D;
      memtoRegE <= hz.MemtoRegD;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa3M      <= '0;
      regWriteM <= 1'b0;
      pcSrcM    <= 1'b0;
      pcSrcW    <= 1'b0;
`ifdef HAZARD_FORWARD_EN
      wa3W      <= '0;
      regWriteW <= 1'b0;
`endif
    end else begin
      wa3M      <= wa3E;
      regWriteM <= regWriteE & hz.CondExE;
      pcSrcM    <= (pcSrcE & hz.CondExE) | hz.BranchTakenE;
      pcSrcW    <= pcSrcM;
`ifdef HAZARD_FORWARD_EN
      wa3W      <= wa3M;
      regWriteW <= regWriteM;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: the driver queues expected outputs, the monitor checks on negedge.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(4)) hz ();

  hazard_unit #(.REG_AW(4), .PC_REG(15)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    string      name;
    logic [7:0] v;   // {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
  } exp_t;

  exp_t q[$];
  int   nTests = 0;
  int   nFail  = 0;

  // Control field {RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE}
  localparam logic [4:0] C_NOP  = 5'b00010;
  localparam logic [4:0] C_WR   = 5'b10010;
  localparam logic [4:0] C_LD   = 5'b11010;
  localparam logic [4:0] C_PC   = 5'b10110;
  localparam logic [4:0] C_WRNC = 5'b10000;
  localparam logic [4:0] C_WRBR = 5'b10011;
  localparam logic [4:0] C_LDBR = 5'b11011;

  task automatic push(input string nm, input logic [7:0] ev);
    exp_t e;
    e.name = nm;
    e.v    = ev;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic [4:0] ctl);
    hz.RA1D         = ra1;
    hz.RA2D         = ra2;
    hz.WA3D         = wa3;
    hz.RegWriteD    = ctl[4];
    hz.MemtoRegD    = ctl[3];
    hz.PCSrcD       = ctl[2];
    hz.CondExE      = ctl[1];
    hz.BranchTakenE = ctl[0];
  endtask

  task automatic step(input string nm, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa3, input logic [4:0] ctl, input logic [7:0] ev);
    @(posedge clk);
    #1;
    drive(ra1, ra2, wa3, ctl);
    push(nm, ev);
  endtask

  task automatic midReset(input string nm);
    @(negedge clk);
    #1;
    reset = 1'b0;
    push(nm, 8'b0000_00_00);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.ForwardAE, hz.ForwardBE};
      nTests++;
      if (got !== e.v) begin
        nFail++;
        $display("FAIL %s: got SF/SD/FD/FE/FA/FB=%b, expected %b", e.name, got, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(4'd0, 4'd0, 4'd0, C_NOP);
    push("reset_init", 8'b0000_00_00);
    @(negedge clk);
    #1;
    reset = 1'b1;

`ifdef HAZARD_FORWARD_EN
    step("nop0",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("add_r1",     4'd2, 4'd3, 4'd1,  C_WR,   8'b0000_00_00);
    step("sub_r2",     4'd1, 4'd3, 4'd2,  C_WR,   8'b0000_00_00);
    step("fwd_m",      4'd1, 4'd5, 4'd7,  C_WR,   8'b0000_10_00);
    step("fwd_w",      4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_01_00);
    step("ldr_r4",     4'd2, 4'd0, 4'd4,  C_LD,   8'b0000_00_00);
    step("ld_stall",   4'd4, 4'd4, 4'd5,  C_WR,   8'b1101_00_00);
    step("ld_release", 4'd4, 4'd4, 4'd5,  C_WR,   8'b0000_00_00);
    step("ld_fwd_w",   4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_01_01);
    step("add_r6",     4'd0, 4'd0, 4'd6,  C_WR,   8'b0000_00_00);
    step("sub_r6",     4'd0, 4'd0, 4'd6,  C_WR,   8'b0000_00_00);
    step("cons_r6",    4'd6, 4'd6, 4'd8,  C_WR,   8'b0000_00_00);
    step("m_over_w",   4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_10_10);
    step("prod_pc",    4'd0, 4'd0, 4'd15, C_WR,   8'b0000_00_00);
    step("cons_pc",    4'd15, 4'd15, 4'd2, C_WR,  8'b0000_00_00);
    step("pc_no_fwd",  4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("ldr_r9",     4'd0, 4'd0, 4'd9,  C_LD,   8'b0000_00_00);
    step("br_ld",      4'd9, 4'd0, 4'd10, C_WRBR, 8'b1111_00_00);
    step("br_m",       4'd9, 4'd0, 4'd10, C_WR,   8'b1010_00_00);
    step("br_w",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0010_00_00);
    step("br_idle",    4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("prod_r3",    4'd0, 4'd0, 4'd3,  C_WR,   8'b0000_00_00);
    step("cons_r3",    4'd3, 4'd0, 4'd4,  C_WR,   8'b0000_00_00);
    step("fwd_r3",     4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_10_00);
    midReset("reset_mid");
    step("post_reset", 4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
`else
    step("nop0",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("add_r1",     4'd2, 4'd3, 4'd1,  C_WR,   8'b0000_00_00);
    step("raw_e",      4'd1, 4'd7, 4'd6,  C_WR,   8'b1101_00_00);
    step("raw_m",      4'd1, 4'd7, 4'd6,  C_WR,   8'b1101_00_00);
    step("raw_go",     4'd1, 4'd7, 4'd6,  C_WR,   8'b0000_00_00);
    step("nop1",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("nop2",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("prod_pc",    4'd0, 4'd0, 4'd15, C_WR,   8'b0000_00_00);
    step("cons_pc_e",  4'd15, 4'd15, 4'd2, C_NOP, 8'b0000_00_00);
    step("cons_pc_m",  4'd15, 4'd0, 4'd0, C_NOP,  8'b0000_00_00);
    step("movpc_d",    4'd0, 4'd3, 4'd15, C_PC,   8'b1010_00_00);
    step("movpc_e",    4'd0, 4'd0, 4'd0,  C_NOP,  8'b1010_00_00);
    step("movpc_m",    4'd0, 4'd0, 4'd0,  C_NOP,  8'b1010_00_00);
    step("movpc_w",    4'd0, 4'd0, 4'd0,  C_NOP,  8'b0010_00_00);
    step("movpc_idle", 4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("add_r1c",    4'd2, 4'd3, 4'd1,  C_WR,   8'b0000_00_00);
    step("condfail_e", 4'd1, 4'd0, 4'd8,  C_WRNC, 8'b1101_00_00);
    step("condfail_m", 4'd1, 4'd0, 4'd8,  C_WR,   8'b0000_00_00);
    step("br_raw",     4'd8, 4'd0, 4'd9,  C_WRBR, 8'b1111_00_00);
    step("br_m",       4'd8, 4'd0, 4'd9,  C_WR,   8'b1010_00_00);
    step("br_w",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0010_00_00);
    step("br_idle",    4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("prod_r3",    4'd0, 4'd0, 4'd3,  C_WR,   8'b0000_00_00);
    step("nop3",       4'd0, 4'd0, 4'd0,  C_NOP,  8'b0000_00_00);
    step("cons_r3",    4'd3, 4'd3, 4'd4,  C_WR,   8'b1101_00_00);
    midReset("reset_mid");
    step("post_reset", 4'd3, 4'd3, 4'd4,  C_WR,   8'b0000_00_00);
`endif
    step("tail_ld",    4'd0, 4'd0, 4'd5,  C_LDBR & 5'b11010, 8'b0000_00_00);

    repeat (2) @(negedge clk);
    #1;
    nTests++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
